req_arbiter83: RTL

//   Shares one resource between 8 requesters using priority-encode arbitration.

---
 rtl/req_arbiter83_if.sv | 25 ++
 rtl/req_arbiter83.sv | 121 ++++++++++++
 2 files changed

// File: rtl/req_arbiter83_if.sv
// Purpose: handshake bundle between requesters and the arbiter.
// Ports: en/req/done are driven by the requester side (master).
//        grant/grant_id/busy/timeout are driven by the arbiter (slave).
interface req_arbiter83_if #(
  parameter int N   = 8,
  parameter int IDW = 3
) ();
  logic           en;
  logic [N-1:0]   req;
  logic           done;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           timeout;

  modport master (
    output en, req, done,
    input  grant, grant_id, busy, timeout
  );

  modport slave (
    input  en, req, done,
    output grant, grant_id, busy, timeout
  );
endinterface

// File: rtl/req_arbiter83.sv
// Purpose: 8-way arbiter, fixed-priority (highest index) or round-robin; holds one
//   registered grant until done, request drop, en low or a watchdog expiry.
// Latency: req sampled at edge k is granted after edge k; every release is followed by
//   at least one idle cycle. Backpressure: requesters hold req until served.
// Ports: clk, rst (async active-high), bus (slave modport: en, req, done in;
//   grant, grant_id, busy, timeout out).
module req_arbiter83 #(
  parameter int N       = 8,
  parameter int IDW     = 3,
  parameter int RR      = 1,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  req_arbiter83_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_nx;
  logic [N-1:0]   grant_q, grant_nx;
  logic [IDW-1:0] id_q, id_nx;
  logic [IDW-1:0] ptr_q, ptr_nx;
  logic [CW-1:0]  cnt_q, cnt_nx;
  logic           to_q, to_nx;

  logic [IDW-1:0] win;
  logic [IDW-1:0] idx;
  logic           found;
  logic           release_now;

  // Winner selection. Round-robin scans upward from rr pointer with the
  // IDW-bit add wrapping 7->0; fixed priority lets the last (highest) set bit win.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    if (RR != 0) begin
      for (int i = 0; i < N; i++) begin
        idx = ptr_q + IDW'(i);
        if (!found && bus.req[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.req[i]) begin
          win = IDW'(i);
        end
      end
    end
  end

  assign release_now = !bus.en || bus.done || !bus.req[id_q] || (cnt_q == CNT_MAX);

  always_comb begin
    state_nx = state;
    grant_nx = grant_q;
    id_nx    = id_q;
    ptr_nx   = ptr_q;
    cnt_nx   = cnt_q;
    to_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en && (|bus.req)) begin
          state_nx = BUSY;
          grant_nx = N'(1) << win;
          id_nx    = win;
          cnt_nx   = '0;
          ptr_nx   = win + 1'b1;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_nx = IDLE;
          grant_nx = '0;
          id_nx    = '0;
          cnt_nx   = '0;
          // Only flag the watchdog when none of the higher-priority causes applied.
          to_nx    = bus.en && !bus.done && bus.req[id_q];
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        id_nx    = '0;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state   <= state_nx;
      grant_q <= grant_nx;
      id_q    <= id_nx;
      ptr_q   <= ptr_nx;
      cnt_q   <= cnt_nx;
      to_q    <= to_nx;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = id_q;
  assign bus.busy     = (state == BUSY);
  assign bus.timeout  = to_q;

endmodule
